// File: rtl/spi_in_fifo.sv
// rtl/spi_in_fifo.sv - oversampled SPI slave receiver feeding a WIDTH-bit word FIFO
// Define SPI_IN_FRAME_ERR_EN to add the sticky frameErr output for words cut short by csN.
module spi_in_fifo #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 4,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          LSB_FIRST = 1'b0,
  localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             slaveChipSelectN,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  input  logic             rdReady,
  output logic [LW-1:0]    level,
  output logic             overrun,
`ifdef SPI_IN_FRAME_ERR_EN
  output logic             frameErr,
`endif
  input  logic             clearOverrun
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // [0] first stage, [1] synchronised value, [2] previous synchronised sclk for edge detect
  logic [2:0]       sclk_sync_q, sclk_sync_d;
  logic [1:0]       mosi_sync_q, mosi_sync_d;
  logic [1:0]       cs_sync_q, cs_sync_d;

  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overrun_q, overrun_d;
`ifdef SPI_IN_FRAME_ERR_EN
  logic             frame_err_q, frame_err_d;
`endif

  logic             cs_active;
  logic             sample_edge;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             fifo_full;
  logic [WIDTH-1:0] shift_next;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    cs_sync_d   = {cs_sync_q[0], slaveChipSelectN};
  end

  assign cs_active = ~cs_sync_q[1];

  always_comb begin
    if (CPOL == CPHA) begin
      sample_edge = sclk_sync_q[1] & ~sclk_sync_q[2];
    end else begin
      sample_edge = ~sclk_sync_q[1] & sclk_sync_q[2];
    end
  end

  always_comb begin
    if (LSB_FIRST) begin
      shift_next = {mosi_sync_q[1], shift_q[WIDTH-1:1]};
    end else begin
      shift_next = {shift_q[WIDTH-2:0], mosi_sync_q[1]};
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    if (!cs_active) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (sample_edge) begin
      shift_d = shift_next;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        push_req  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push
  assign fifo_full = (level_q == FULL_LVL);
  assign pop       = (level_q != '0) & rdReady;
  assign push_ok   = push_req & (~fifo_full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_next;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clearOverrun) begin
      overrun_d = 1'b0;
    end
    if (push_req && fifo_full && !pop) begin
      overrun_d = 1'b1;
    end
  end

`ifdef SPI_IN_FRAME_ERR_EN
  // bit_cnt is only non-zero on the first deselected cycle when a word was cut short
  always_comb begin
    frame_err_d = frame_err_q;
    if (clearOverrun) begin
      frame_err_d = 1'b0;
    end
    if (!cs_active && (bit_cnt_q != '0)) begin
      frame_err_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!resetN) begin
      sclk_sync_q <= {3{CPOL}};
      mosi_sync_q <= '0;
      cs_sync_q   <= 2'b11;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
`ifdef SPI_IN_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
`ifdef SPI_IN_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign rdValid = (level_q != '0);
  assign rdData  = rdValid ? mem_q[rd_ptr_q] : '0;
  assign level   = level_q;
  assign overrun = overrun_q;
`ifdef SPI_IN_FRAME_ERR_EN
  assign frameErr = frame_err_q;
`endif

endmodule
